pam_tx_gen: RTL and testbench

- Parametrised PAM-M transmit source. Successor to the fixed PAM4 PRBS→Gray→PAM chain.
- Generates a selectable PRBS, or accepts external data, and packs BITS_PER_SYM bits per symbol.
- Gray-encodes each symbol, maps it to a signed voltage level, and presents it on a ready/valid output with backpressure.
- Adds error injection and an accepted-symbol counter. Feeds the channel model in the SERDES simulation.

---
 rtl/pam_tx_gen_if.sv | 25 ++
 rtl/pam_tx_gen.sv | 156 +++++++++++++++
 tb/tb_pam_tx_gen.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pam_tx_gen_if.sv
// Symbol stream interface: external data input and the PAM level output, both ready/valid.
interface pam_tx_gen_if #(
    parameter int unsigned BITS_PER_SYM = 2,
    parameter int unsigned VOLT_W       = 8
);
    logic [BITS_PER_SYM-1:0] ext_data;
    logic                    ext_valid;
    logic                    ext_ready;
    logic [BITS_PER_SYM-1:0] sym_out;
    logic signed [VOLT_W-1:0] level_out;
    logic                    out_valid;
    logic                    out_ready;

    // Generator side
    modport master (
        input  ext_data, ext_valid, out_ready,
        output ext_ready, sym_out, level_out, out_valid
    );

    // Producer of external data / consumer of symbols
    modport slave (
        output ext_data, ext_valid, out_ready,
        input  ext_ready, sym_out, level_out, out_valid
    );
endinterface

// File: rtl/pam_tx_gen.sv
// PAM-M transmit source: PRBS7/15/31 or external bits, Gray coding, signed level mapping,
// error injection and an accepted-symbol counter behind a ready/valid output.
module pam_tx_gen #(
    parameter int unsigned BITS_PER_SYM = 2,
    parameter int unsigned VOLT_W       = 8,
    parameter int unsigned LEVEL_STEP   = 32,
    parameter logic [30:0] SEED         = 31'h7FFFFFFF,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             seed_load,
    input  logic [30:0]      seed_val,
    input  logic             err_inject,
    output logic [CNT_W-1:0] sym_count,
    pam_tx_gen_if.master     bus
);

    localparam int unsigned M = 1 << BITS_PER_SYM;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e                   state_q, state_d;
    logic [30:0]              lfsr_q, lfsr_d, lfsr_step;
    logic [1:0]               mode_q;
    logic                     err_pending_q;
    logic [BITS_PER_SYM-1:0]  sym_q;
    logic signed [VOLT_W-1:0] level_q, level_d;
    logic                     valid_q;
    logic [CNT_W-1:0]         count_q;

    logic                     run, space, gen, accept, flip, fb;
    logic [BITS_PER_SYM-1:0]  prbs_bits, raw, gray, gray_err;
    int                       lvl_full;

    // Active-length mask; mode 3 keeps the full register (LFSR is idle there)
    function automatic logic [30:0] len_mask(input logic [1:0] m);
        case (m)
            2'd0:    return 31'h0000007F;
            2'd1:    return 31'h00007FFF;
            default: return 31'h7FFFFFFF;
        endcase
    endfunction

    // Mask to the active length; an all-zero seed would lock the LFSR, so force it to 1
    function automatic logic [30:0] fix_seed(input logic [30:0] v, input logic [1:0] m);
        logic [30:0] x;
        x = v & len_mask(m);
        return (x == 31'd0) ? 31'd1 : x;
    endfunction

    function automatic logic lfsr_fb(input logic [30:0] s, input logic [1:0] m);
        case (m)
            2'd0:    return s[6] ^ s[5];
            2'd1:    return s[14] ^ s[13];
            default: return s[30] ^ s[27];
        endcase
    endfunction

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= StIdle;
        else          state_q <= state_d;
    end

    // FSM next state: en alone moves between idle and run
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (en)  state_d = StRun;
            StRun:  if (!en) state_d = StIdle;
            default:         state_d = StIdle;
        endcase
    end

    // FSM outputs: a new symbol is made only in run with a free output slot
    always_comb begin
        run           = (state_q == StRun);
        space         = !valid_q || bus.out_ready;
        gen           = run && space && ((mode != 2'd3) || bus.ext_valid);
        accept        = valid_q && bus.out_ready;
        bus.ext_ready = run && (mode == 2'd3) && space;
    end

    // Step the LFSR BITS_PER_SYM times; the first bit out becomes the symbol MSB
    always_comb begin
        lfsr_step = lfsr_q;
        prbs_bits = '0;
        fb        = 1'b0;
        for (int i = 0; i < BITS_PER_SYM; i++) begin
            fb                           = lfsr_fb(lfsr_step, mode);
            prbs_bits[BITS_PER_SYM-1-i] = fb;
            lfsr_step                    = {lfsr_step[29:0], fb} & len_mask(mode);
        end
    end

    // LFSR next state: explicit load beats mode-change reload beats a step
    always_comb begin
        lfsr_d = lfsr_q;
        if (seed_load)                    lfsr_d = fix_seed(seed_val, mode);
        else if (mode != mode_q)          lfsr_d = fix_seed(SEED, mode);
        else if (gen && (mode != 2'd3))   lfsr_d = lfsr_step;
    end

    // Gray code, optional LSB flip, then signed level at full width before truncation
    always_comb begin
        raw         = (mode == 2'd3) ? bus.ext_data : prbs_bits;
        gray        = raw ^ (raw >> 1);
        flip        = err_pending_q || err_inject;
        gray_err    = gray;
        gray_err[0] = gray[0] ^ flip;
        lvl_full    = (2 * int'(gray_err) - (int'(M) - 1)) * int'(LEVEL_STEP);
        level_d     = lvl_full[VOLT_W-1:0];
    end

    // LFSR, mode tracker and pending-error flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q        <= SEED;
            mode_q        <= 2'd0;
            err_pending_q <= 1'b0;
        end else begin
            lfsr_q <= lfsr_d;
            mode_q <= mode;
            if (gen)             err_pending_q <= 1'b0;
            else if (err_inject) err_pending_q <= 1'b1;
        end
    end

    // Output register and accepted-symbol counter; data holds while stalled or drained
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sym_q   <= '0;
            level_q <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            if (gen) begin
                sym_q   <= gray_err;
                level_q <= level_d;
                valid_q <= 1'b1;
            end else if (accept) begin
                valid_q <= 1'b0;
            end
            if (accept) count_q <= count_q + CNT_W'(1);
        end
    end

    assign bus.sym_out   = sym_q;
    assign bus.level_out = level_q;
    assign bus.out_valid = valid_q;
    assign sym_count     = count_q;

endmodule

// File: tb/tb_pam_tx_gen.sv
// Scoreboard bench: DUT A is PAM4 with a 32-bit counter, DUT B is PAM2 with a 4-bit counter.
module tb_pam_tx_gen;

    localparam int STEP = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a_n, rst_b_n;
    logic        en_a, seed_load_a, err_inject_a, en_b;
    logic [1:0]  mode_a;
    logic [30:0] seed_val_a;
    logic [31:0] cnt_a;
    logic [3:0]  cnt_b;

    pam_tx_gen_if #(.BITS_PER_SYM(2), .VOLT_W(8)) bus_a ();
    pam_tx_gen_if #(.BITS_PER_SYM(1), .VOLT_W(8)) bus_b ();

    pam_tx_gen #(.BITS_PER_SYM(2), .VOLT_W(8), .LEVEL_STEP(32), .CNT_W(32)) dut_a (
        .clk        (clk),
        .reset_n    (rst_a_n),
        .en         (en_a),
        .mode       (mode_a),
        .seed_load  (seed_load_a),
        .seed_val   (seed_val_a),
        .err_inject (err_inject_a),
        .sym_count  (cnt_a),
        .bus        (bus_a)
    );

    pam_tx_gen #(.BITS_PER_SYM(1), .VOLT_W(8), .LEVEL_STEP(32), .CNT_W(4)) dut_b (
        .clk        (clk),
        .reset_n    (rst_b_n),
        .en         (en_b),
        .mode       (2'd0),
        .seed_load  (1'b0),
        .seed_val   (31'd0),
        .err_inject (1'b0),
        .sym_count  (cnt_b),
        .bus        (bus_b)
    );

    int total = 0;
    int bad   = 0;
    int qa[$], qb[$], obs_a[$], bits_b[$];
    int acc_a = 0, acc_b = 0;

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference LFSR: produces nbits bits MSB-first from state s
    function automatic void mgen(inout logic [30:0] s, input int m, input int nbits,
                                 output int sym);
        int   l, t;
        logic nb;
        case (m)
            0:       begin l = 7;  t = 6;  end
            1:       begin l = 15; t = 14; end
            default: begin l = 31; t = 28; end
        endcase
        sym = 0;
        for (int k = 0; k < nbits; k++) begin
            nb = s[l-1] ^ s[t-1];
            s  = {s[29:0], nb};
            if (l < 31) s = s & ((31'd1 << l) - 31'd1);
            sym = (sym << 1) | int'(nb);
        end
    endfunction

    function automatic int gray(input int b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic signed [63:0] lvl(input int g, input int m);
        return (2 * g - (m - 1)) * STEP;
    endfunction

    // Expected PAM4 Gray symbols for DUT A, skipping the first `skip` symbols
    task automatic fill_a(input logic [30:0] seed, input int m, input int skip, input int n);
        logic [30:0] s;
        int          b;
        s = seed;
        for (int i = 0; i < skip + n; i++) begin
            mgen(s, m, 2, b);
            if (i >= skip) qa.push_back(gray(b));
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard A: pop on every accept
    always @(negedge clk) begin
        if (rst_a_n && bus_a.out_valid && bus_a.out_ready) begin
            if (qa.size() == 0) begin
                check("a_sb_underflow", 0, 1);
            end else begin
                int g;
                g = qa.pop_front();
                check("a_sym", bus_a.sym_out, g);
                check("a_level", bus_a.level_out, lvl(g, 4));
                check("a_count", cnt_a, acc_a);
                obs_a.push_back(int'(bus_a.sym_out));
            end
            acc_a++;
        end
    end

    // Scoreboard B: also checks the 4-bit counter wraps 15 -> 0
    always @(negedge clk) begin
        if (rst_b_n && bus_b.out_valid && bus_b.out_ready) begin
            if (qb.size() == 0) begin
                check("b_sb_underflow", 0, 1);
            end else begin
                int g;
                g = qb.pop_front();
                check("b_sym", bus_b.sym_out, g);
                check("b_level", bus_b.level_out, lvl(g, 2));
                check("b_count", cnt_b, acc_b % 16);
                bits_b.push_back(int'(bus_b.sym_out));
            end
            acc_b++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]  hs;
        logic [7:0]  hl;
        logic [31:0] hc;
        int          acc0, pushes, mism;
        bit          nonconst;
        logic [30:0] sb;
        int          b;

        rst_a_n = 1'b0; rst_b_n = 1'b0;
        en_a = 1'b0; mode_a = 2'd0; seed_load_a = 1'b0; seed_val_a = '0; err_inject_a = 1'b0;
        bus_a.ext_data = '0; bus_a.ext_valid = 1'b0; bus_a.out_ready = 1'b0;
        en_b = 1'b0; bus_b.ext_data = '0; bus_b.ext_valid = 1'b0; bus_b.out_ready = 1'b0;
        #12;
        check("rst_a_valid", bus_a.out_valid, 0);
        check("rst_a_sym", bus_a.sym_out, 0);
        check("rst_a_level", bus_a.level_out, 0);
        check("rst_a_ext_ready", bus_a.ext_ready, 0);
        check("rst_a_count", cnt_a, 0);
        check("rst_b_count", cnt_b, 0);
        @(negedge clk);
        rst_a_n = 1'b1; rst_b_n = 1'b1;

        // PRBS7 from seed 7F: first four symbols 00,00,00,11 then the model
        tick();
        seed_val_a = 31'h7F; seed_load_a = 1'b1;
        tick();
        seed_load_a = 1'b0;
        qa.push_back(0); qa.push_back(0); qa.push_back(0); qa.push_back(3);
        fill_a(31'h7F, 0, 4, 150);
        en_a = 1'b1; bus_a.out_ready = 1'b1;
        tick();
        check("a_latency_pre", bus_a.out_valid, 0);
        tick();
        check("a_latency_first", bus_a.out_valid, 1);
        tick(10);

        // Stall 5 cycles with two error pulses: held data stable, one later symbol flipped
        bus_a.out_ready = 1'b0;
        hs = 8'(bus_a.sym_out); hl = bus_a.level_out; hc = cnt_a;
        qa[1] = qa[1] ^ 1;
        for (int i = 0; i < 5; i++) begin
            err_inject_a = (i == 0 || i == 2);
            tick();
            check("a_stall_valid", bus_a.out_valid, 1);
            check("a_stall_sym", bus_a.sym_out, hs);
            check("a_stall_level", bus_a.level_out, $signed(hl));
            check("a_stall_count", cnt_a, hc);
        end
        err_inject_a = 1'b0;
        bus_a.out_ready = 1'b1;
        tick(12);
        en_a = 1'b0;
        tick(4);
        check("a_drained", bus_a.out_valid, 0);
        check("a_count_total", cnt_a, acc_a);
        qa.delete();

        // PRBS31 with zero seed: forced to 1, output must become non-constant
        mode_a = 2'd2;
        tick();
        seed_val_a = 31'd0; seed_load_a = 1'b1;
        tick();
        seed_load_a = 1'b0;
        fill_a(31'd1, 2, 0, 100);
        obs_a.delete();
        en_a = 1'b1;
        tick(40);
        en_a = 1'b0;
        tick(4);
        nonconst = 1'b0;
        foreach (obs_a[i]) if (obs_a[i] != obs_a[0]) nonconst = 1'b1;
        check("a_prbs31_nonconst", nonconst, 1);
        qa.delete();

        // External mode: one output per handshake, Gray coded
        mode_a = 2'd3;
        tick();
        en_a = 1'b1;
        acc0 = acc_a; pushes = 0;
        for (int i = 0; i < 16; i++) begin
            bus_a.ext_valid = (i % 2 == 0);
            bus_a.ext_data  = (i < 8) ? 2'b10 : 2'((i / 2) % 4);
            #3;
            if (bus_a.ext_valid && bus_a.ext_ready) begin
                qa.push_back(gray(int'(bus_a.ext_data)));
                pushes++;
            end
            tick();
        end
        bus_a.ext_valid = 1'b1; bus_a.ext_data = 2'b01; bus_a.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #3;
            if (bus_a.out_valid) check("a_ext_ready_stall", bus_a.ext_ready, 0);
            if (bus_a.ext_ready) begin
                qa.push_back(gray(1));
                pushes++;
            end
            tick();
        end
        bus_a.ext_valid = 1'b0; bus_a.out_ready = 1'b1;
        tick(4);
        check("a_ext_outputs", acc_a - acc0, pushes);
        check("a_ext_sb_empty", qa.size(), 0);
        en_a = 1'b0;
        tick(3);

        // Reset mid-stream with a held symbol, then restart from SEED
        mode_a = 2'd0;
        tick();
        fill_a(31'h7F, 0, 0, 100);
        en_a = 1'b1;
        tick(6);
        bus_a.out_ready = 1'b0;
        tick(2);
        check("a_pre_reset_valid", bus_a.out_valid, 1);
        #2;
        rst_a_n = 1'b0;
        #1;
        check("a_rst_valid", bus_a.out_valid, 0);
        check("a_rst_sym", bus_a.sym_out, 0);
        check("a_rst_level", bus_a.level_out, 0);
        check("a_rst_count", cnt_a, 0);
        qa.delete();
        acc_a = 0;
        qa.push_back(0); qa.push_back(0); qa.push_back(0); qa.push_back(3);
        fill_a(31'h7F, 0, 4, 100);
        bus_a.out_ready = 1'b1;
        @(negedge clk);
        rst_a_n = 1'b1;
        tick(10);
        en_a = 1'b0;
        tick(4);
        check("a_restart_accepts", acc_a >= 4, 1);
        check("a_restart_count", cnt_a, acc_a);

        // PAM2 free run: period 127 and 4-bit counter wrap
        sb = 31'h7F;
        for (int i = 0; i < 300; i++) begin
            mgen(sb, 0, 1, b);
            qb.push_back(b);
        end
        en_b = 1'b1; bus_b.out_ready = 1'b1;
        tick(265);
        en_b = 1'b0;
        tick(3);
        check("b_len", bits_b.size() >= 254, 1);
        mism = 0;
        if (bits_b.size() >= 254)
            for (int i = 0; i < 127; i++) if (bits_b[i] != bits_b[i+127]) mism++;
        check("b_period127", mism, 0);
        check("b_count_final", cnt_b, acc_b % 16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
